// File: rtl/zeroriscy_dslv_pkg.sv
// Shared types and constants for the data-side slave decoder/multiplexer.
package zeroriscy_dslv_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned BE_W  = 4;

  // Default slave regions on the data slave port
  localparam logic [BUS_W-1:0] SLV0_BASE = 32'h8010_0000;
  localparam logic [BUS_W-1:0] SLV1_BASE = 32'h8018_0000;
  localparam logic [BUS_W-1:0] SLV_MASK  = 32'hFFF8_0000;

  // Kind of target selected by the address decode
  typedef enum logic [1:0] {
    TGT_SRAM = 2'd0,
    TGT_HS   = 2'd1,
    TGT_ERR  = 2'd2
  } tgt_kind_e;

  // Request payload broadcast to every slave
  typedef struct packed {
    logic             we;
    logic [BE_W-1:0]  be;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
  } dslv_req_t;

  // Width of a target ID: slaves 0..nslv-1 plus the error target
  function automatic int unsigned id_w(input int unsigned nslv);
    return (nslv < 1) ? 1 : $clog2(nslv + 1);
  endfunction

  // ID of the decode-error target
  function automatic int unsigned err_id(input int unsigned nslv);
    return nslv;
  endfunction

endpackage

// File: rtl/zeroriscy_id_fifo.sv
// Synchronous FIFO of target IDs for outstanding transactions, head visible combinationally.
module zeroriscy_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head_c,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign o_head_c  = r_mem[r_rd_ptr];

  // A push into a full FIFO or a pop from an empty one is dropped
  assign w_push = i_push & ~o_full_c;
  assign w_pop  = i_pop & ~o_empty_c;

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/zeroriscy_dslv_mux.sv
// Data-slave decoder/multiplexer: decode, in-order outstanding tracking and rdata return.
module zeroriscy_dslv_mux
  import zeroriscy_dslv_pkg::*;
#(
  parameter int unsigned        NSLV     = 4,
  parameter int unsigned        OUTST    = 2,
  parameter logic [NSLV*32-1:0] BASE     = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] MASK     = {NSLV{32'hFFF8_0000}},
  parameter logic [NSLV-1:0]    SRAM_SLV = {NSLV{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p_req,
  input  logic                 p_we,
  input  logic [3:0]           p_be,
  input  logic [31:0]          p_addr,
  input  logic [31:0]          p_wdata,
  output logic                 p_gnt,
  output logic                 p_rvalid,
  output logic [31:0]          p_rdata,
  output logic                 p_err,
  output logic [NSLV-1:0]      s_req,
  output logic                 s_we,
  output logic [3:0]           s_be,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  input  logic [NSLV-1:0]      s_gnt,
  input  logic [NSLV-1:0]      s_rvalid,
  input  logic [NSLV*32-1:0]   s_rdata
);

  localparam int unsigned    ID_W   = id_w(NSLV);
  localparam int unsigned    CNT_W  = $clog2(OUTST) + 1;
  localparam logic [ID_W-1:0] ERR_ID = ID_W'(err_id(NSLV));

  dslv_req_t        w_bus;
  logic [ID_W-1:0]  w_tgt;
  tgt_kind_e        w_kind;
  logic             w_tgt_gnt;
  logic             w_room;
  logic             w_idle;
  logic             w_can;
  logic             w_push;
  logic             w_pop;
  logic [ID_W-1:0]  w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_head_rv;
  logic             w_head_err;
  logic [31:0]      w_head_rdata;

  logic [ID_W-1:0]  r_last_tgt;
  logic [NSLV-1:0]  r_rv_sram;
  logic             r_rv_err;

  // Broadcast request payload to all slaves
  assign w_bus   = '{we: p_we, be: p_be, addr: p_addr, wdata: p_wdata};
  assign s_we    = w_bus.we;
  assign s_be    = w_bus.be;
  assign s_addr  = w_bus.addr;
  assign s_wdata = w_bus.wdata;

  // Address decode: lowest-index hit wins, no hit selects the error target
  always_comb begin
    w_tgt = ERR_ID;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((p_addr & MASK[32*i +: 32]) == BASE[32*i +: 32]) w_tgt = ID_W'(i);
    end
  end

  // Classify the decoded target and pick its grant line
  always_comb begin
    w_kind    = TGT_ERR;
    w_tgt_gnt = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (w_tgt == ID_W'(i)) begin
        w_kind    = SRAM_SLV[i] ? TGT_SRAM : TGT_HS;
        w_tgt_gnt = s_gnt[i];
      end
    end
  end

  // Only one target may be in flight at a time so responses return in order
  assign w_room = ~w_full;
  assign w_idle = (w_count == '0);
  assign w_can  = p_req & w_room & (w_idle | (w_tgt == r_last_tgt));

  // Grant and per-slave request, combinational from the incoming request
  always_comb begin
    s_req = '0;
    p_gnt = 1'b0;
    unique case (w_kind)
      TGT_SRAM: p_gnt = w_can;
      TGT_HS:   p_gnt = w_can & w_tgt_gnt;
      default:  p_gnt = w_can;
    endcase
    for (int i = 0; i < NSLV; i++) begin
      if (w_tgt == ID_W'(i)) s_req[i] = w_can;
    end
  end

  assign w_push = p_gnt;

  zeroriscy_id_fifo #(
    .DEPTH (OUTST),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data    (w_tgt),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  // Synthesised response valids for SRAM and error targets, plus last pushed target
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rv_sram  <= '0;
      r_rv_err   <= 1'b0;
      r_last_tgt <= '0;
    end else begin
      r_rv_sram <= s_req & SRAM_SLV;
      r_rv_err  <= w_push & (w_tgt == ERR_ID);
      if (w_push) r_last_tgt <= w_tgt;
    end
  end

  // Response valid and data of the target at the FIFO head
  always_comb begin
    w_head_rv    = 1'b0;
    w_head_err   = 1'b0;
    w_head_rdata = '0;
    if (w_head == ERR_ID) begin
      w_head_rv  = r_rv_err;
      w_head_err = 1'b1;
    end
    for (int i = 0; i < NSLV; i++) begin
      if (w_head == ID_W'(i)) begin
        w_head_rv    = SRAM_SLV[i] ? r_rv_sram[i] : s_rvalid[i];
        w_head_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  // Valids arriving with nothing outstanding or from a non-head slave are ignored
  assign w_pop    = ~w_empty & w_head_rv;
  assign p_rvalid = w_pop;
  assign p_err    = w_pop & w_head_err;
  assign p_rdata  = w_pop ? w_head_rdata : 32'h0;

endmodule

// File: tb/tb_zeroriscy_dslv_mux.sv
// Scoreboard bench: two SRAM slaves, one handshake slave, plus unmapped space.
module tb_zeroriscy_dslv_mux;
  import zeroriscy_dslv_pkg::*;

  localparam int unsigned NSLV    = 3;
  localparam logic [31:0] HS_BASE = 32'h8020_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              p_req = 1'b0;
  logic              p_we = 1'b0;
  logic [3:0]        p_be = 4'h0;
  logic [31:0]       p_addr = 32'h0;
  logic [31:0]       p_wdata = 32'h0;
  logic              p_gnt;
  logic              p_rvalid;
  logic [31:0]       p_rdata;
  logic              p_err;
  logic [NSLV-1:0]   s_req;
  logic              s_we;
  logic [3:0]        s_be;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [NSLV-1:0]   s_gnt;
  logic [NSLV-1:0]   s_rvalid;
  logic [NSLV*32-1:0] s_rdata;

  logic        hs_gnt = 1'b0;
  logic        hs_rv = 1'b0;
  logic [31:0] hs_rdata = 32'hBAD0_0000;
  logic [31:0] sram_q [2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hs_pend[$];
  int          n_checks = 0;
  int          n_fail = 0;

  // SRAM slaves ignore gnt/rvalid, so their rvalid lines are held high as noise
  assign s_gnt    = {hs_gnt, 2'b00};
  assign s_rvalid = {hs_rv, 2'b11};
  assign s_rdata  = {hs_rdata, sram_q[1], sram_q[0]};

  zeroriscy_dslv_mux #(
    .NSLV     (NSLV),
    .OUTST    (2),
    .BASE     ({HS_BASE, SLV1_BASE, SLV0_BASE}),
    .MASK     ({3{SLV_MASK}}),
    .SRAM_SLV (3'b011)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .p_req    (p_req),
    .p_we     (p_we),
    .p_be     (p_be),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_gnt    (p_gnt),
    .p_rvalid (p_rvalid),
    .p_rdata  (p_rdata),
    .p_err    (p_err),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_be     (s_be),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_gnt    (s_gnt),
    .s_rvalid (s_rvalid),
    .s_rdata  (s_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_val(input int idx, input logic [31:0] a);
    return a ^ ((idx == 0) ? 32'h1111_0000 : 32'h2222_0000);
  endfunction

  function automatic logic [31:0] hs_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Reference decode: 0/1 SRAM, 2 handshake, 3 unmapped
  function automatic int model_tgt(input logic [31:0] a);
    if ((a & SLV_MASK) == SLV0_BASE) return 0;
    if ((a & SLV_MASK) == SLV1_BASE) return 1;
    if ((a & SLV_MASK) == HS_BASE)   return 2;
    return 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // SRAM slave model: data appears the cycle after its request
  initial begin
    sram_q[0] = 32'h0;
    sram_q[1] = 32'h0;
  end
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (s_req[i]) sram_q[i] <= sram_val(i, s_addr);
    end
  end

  // One bus cycle: drive after the edge, sample at negedge, record granted requests
  task automatic cyc(input logic req, input logic we, input logic [31:0] addr,
                     input logic hsg, input logic hsrv);
    exp_t e;
    int   t;
    @(posedge clk);
    #1;
    p_req   = req;
    p_we    = we;
    p_addr  = addr;
    p_be    = 4'hF;
    p_wdata = ~addr;
    hs_gnt  = hsg;
    hs_rv   = hsrv;
    if (hsrv && hs_pend.size() > 0) hs_rdata = hs_val(hs_pend.pop_front());
    else if (hsrv) hs_rdata = 32'hDEAD_BEEF;
    else hs_rdata = 32'hBAD0_0000;
    @(negedge clk);
    if (p_gnt) begin
      t = model_tgt(addr);
      e.err = (t == 3);
      if (t == 3)      e.rdata = 32'h0;
      else if (t == 2) e.rdata = hs_val(addr);
      else             e.rdata = sram_val(t, addr);
      sb.push_back(e);
      if (t == 2) hs_pend.push_back(addr);
    end
  endtask

  // Response monitor: every rvalid must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (p_rvalid) begin
        if (sb.size() == 0) begin
          check("rv_unexpected", 32'(p_rvalid), 32'h0);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", p_rdata, e.rdata);
          check("rsp_err", 32'(p_err), 32'(e.err));
        end
      end else begin
        check("rdata_idle", p_rdata, 32'h0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rvalid", 32'(p_rvalid), 32'h0);
    check("rst_err", 32'(p_err), 32'h0);
    check("rst_gnt", 32'(p_gnt), 32'h0);

    // SRAM read, one-cycle latency
    cyc(1'b1, 1'b0, 32'h8010_0004, 1'b0, 1'b0);
    check("s1_gnt", 32'(p_gnt), 32'h1);
    check("s1_sreq", 32'(s_req), 32'h1);
    check("s1_saddr", s_addr, 32'h8010_0004);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("s1_rvalid", 32'(p_rvalid), 32'h1);

    // Back-to-back reads to slave 1
    cyc(1'b1, 1'b0, 32'h8018_0000, 1'b0, 1'b0);
    check("s2_gnt0", 32'(p_gnt), 32'h1);
    check("s2_sreq", 32'(s_req), 32'h2);
    cyc(1'b1, 1'b0, 32'h8018_0004, 1'b0, 1'b0);
    check("s2_gnt1", 32'(p_gnt), 32'h1);
    check("s2_rv0", 32'(p_rvalid), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("s2_rv1", 32'(p_rvalid), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Decode-error write
    cyc(1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b0);
    check("s3_gnt", 32'(p_gnt), 32'h1);
    check("s3_sreq", 32'(s_req), 32'h0);
    check("s3_swe", 32'(s_we), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("s3_rvalid", 32'(p_rvalid), 32'h1);
    check("s3_err", 32'(p_err), 32'h1);

    // Handshake slave without grant: request raised, not accepted
    cyc(1'b1, 1'b0, HS_BASE, 1'b0, 1'b0);
    check("s4_nogrant_gnt", 32'(p_gnt), 32'h0);
    check("s4_nogrant_sreq", 32'(s_req), 32'h4);

    // Handshake with 3-cycle latency holds off a request to an SRAM slave
    cyc(1'b1, 1'b0, HS_BASE + 32'h10, 1'b1, 1'b0);
    check("s4_hs_gnt", 32'(p_gnt), 32'h1);
    check("s4_hs_sreq", 32'(s_req), 32'h4);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b0, 32'h8010_0008, 1'b0, 1'b0);
      check("s4_hold_gnt", 32'(p_gnt), 32'h0);
      check("s4_hold_rv", 32'(p_rvalid), 32'h0);
    end
    cyc(1'b1, 1'b0, 32'h8010_0008, 1'b0, 1'b1);
    check("s4_pop_rv", 32'(p_rvalid), 32'h1);
    check("s4_pop_gnt", 32'(p_gnt), 32'h0);
    cyc(1'b1, 1'b0, 32'h8010_0008, 1'b0, 1'b0);
    check("s4_take_gnt", 32'(p_gnt), 32'h1);
    check("s4_take_sreq", 32'(s_req), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("s4_sram_rv", 32'(p_rvalid), 32'h1);

    // Fill with a handshake slave that never responds
    cyc(1'b1, 1'b0, HS_BASE, 1'b1, 1'b0);
    check("s5_gnt0", 32'(p_gnt), 32'h1);
    cyc(1'b1, 1'b0, HS_BASE + 32'h4, 1'b1, 1'b0);
    check("s5_gnt1", 32'(p_gnt), 32'h1);
    cyc(1'b1, 1'b0, HS_BASE + 32'h8, 1'b1, 1'b0);
    check("s5_full_gnt", 32'(p_gnt), 32'h0);
    check("s5_full_sreq", 32'(s_req), 32'h0);

    // Reset with two outstanding; a late response must be dropped
    @(posedge clk);
    #1;
    p_req  = 1'b0;
    hs_gnt = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    hs_pend.delete();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("s6_drop_rv", 32'(p_rvalid), 32'h0);
    cyc(1'b1, 1'b0, 32'h8010_000C, 1'b0, 1'b0);
    check("s6_gnt", 32'(p_gnt), 32'h1);
    check("s6_sreq", 32'(s_req), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("s6_rvalid", 32'(p_rvalid), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zeroriscy_dslv_mux.md
Name: zeroriscy_dslv_mux

Overview:
- Parametrised data-side slave decoder/multiplexer for the core's data slave port; replaces hard-coded per-slave address compares and rdata select registers.
- Sits between the crossbar data-slave port (req/gnt/rvalid) and NSLV slaves.
- Each slave is either a fixed-latency SRAM (no gnt/rvalid, rdata valid 1 cycle after req) or a handshake slave.
- Tracks outstanding transactions in order, routes rdata back, and returns a decode error for unmapped addresses.

Parameters:
- NSLV, 4: number of slaves.
- OUTST, 2: max outstanding transactions (FIFO depth, power of 2, >=2).
- BASE, {NSLV{32'h0}}: packed NSLV*32 base addresses; slave i uses bits [32*i+:32].
- MASK, {NSLV{32'hFFF8_0000}}: packed NSLV*32 compare masks.
- SRAM_SLV, {NSLV{1'b1}}: bit i=1 means slave i is fixed 1-cycle SRAM; its s_gnt/s_rvalid inputs are ignored.

Ports:
- clk in 1: clock.
- reset in 1: synchronous, active-high reset.
- p_req in 1: upstream request.
- p_we in 1: write enable.
- p_be in 4: byte enables.
- p_addr in 32: address.
- p_wdata in 32: write data.
- p_gnt out 1: request accepted this cycle.
- p_rvalid out 1: response valid.
- p_rdata out 32: read data.
- p_err out 1: decode error, qualified by p_rvalid.
- s_req out NSLV: per-slave request.
- s_we out 1: broadcast write enable.
- s_be out 4: broadcast byte enables.
- s_addr out 32: broadcast address.
- s_wdata out 32: broadcast write data.
- s_gnt in NSLV: slave grant (handshake slaves only).
- s_rvalid in NSLV: slave response valid (handshake slaves only).
- s_rdata in NSLV*32: packed slave read data.

Behaviour:
- Decode: hit[i] = ((p_addr & MASK_i) == BASE_i). Lowest index hit wins. No hit = error target (ERR).
- Response FIFO: depth OUTST, each entry holds a target ID (0..NSLV-1 or ERR); count register 0..OUTST.
- Accept condition, acc = p_req & (count<OUTST) & (count==0 | tgt==last_tgt). last_tgt is the ID of the most recent push. This restriction guarantees in-order returns. No bypass when full; a pop in the same cycle does not free space.
- Grant by target type:
  - SRAM target: s_req[tgt]=acc; p_gnt=acc; push.
  - Handshake target: s_req[tgt]=p_req & (count<OUTST) & (count==0 | tgt==last_tgt); p_gnt=s_req[tgt]&s_gnt[tgt]; push on p_gnt.
  - ERR target: p_gnt=acc; push ERR; no s_req asserted.
- Grant and all s_req outputs are combinational from p_req/p_addr, same cycle.
- Internal response valid:
  - rv[i] = s_rvalid[i] for handshake slaves.
  - rv[i] = s_req[i] registered for SRAM slaves.
  - rv_err = registered ERR push.
- Response: when count>0 and rv[head], p_rvalid=1 for one cycle and pop.
  - Slave head: p_rdata=s_rdata[head], p_err=0.
  - ERR head: p_rdata=0, p_err=1. An error write still returns rvalid.
- Latency: SRAM or ERR responds exactly 1 cycle after grant. Handshake slave responds per slave timing, minimum 1 cycle.
- p_rdata=0 whenever p_rvalid=0.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Spurious rv with count==0, or rv from a non-head slave: ignored, no pop, p_rvalid=0.
- Different-slave request while non-empty: held off (p_gnt=0) until the FIFO drains to empty; the request is taken in the same cycle count reaches 0.
- Reset (sync): count=0, pointers=0, last_tgt=0, rv regs=0. Outputs after reset: p_gnt follows decode with count=0; p_rvalid=0, p_rdata=0, p_err=0. Responses for transactions in flight at reset are dropped.
- Widths: count is $clog2(OUTST)+1 bits; ID is $clog2(NSLV+1) bits; ERR ID = NSLV.

Decomposition:
- Package zeroriscy_dslv_pkg: ID width function, ERR ID constant, default BASE/MASK constants (8010_0000 and 8018_0000 regions, mask FFF8_0000).
- One sub-module zeroriscy_id_fifo: parametrised synchronous FIFO (depth, width) with push/pop/full/empty/count and head output.
- Decode, grant and response mux live in the top.

Test Plan:
- SRAM read: NSLV=2, BASE0=8010_0000, p_req read 8010_0004 -> p_gnt=1 same cycle; s_req=2'b01; next cycle p_rvalid=1, p_rdata=s_rdata0, p_err=0.
- Back-to-back same slave: reads to 8018_0000 then 8018_0004 on consecutive cycles, OUTST=2 -> both granted; rvalids on cycles 1 and 2 carry slave-1 data in order.
- Slave switch hold-off: a handshake slave with 3-cycle latency has 1 outstanding; request to an SRAM slave -> p_gnt=0 until the handshake rvalid pop, granted the same cycle count reaches 0.
- Decode error: write to 0000_1000 -> p_gnt=1, no s_req; next cycle p_rvalid=1, p_err=1, p_rdata=0.
- Full: handshake slave never asserts rvalid, 2 grants -> third p_req gets p_gnt=0, count=2.
- Reset mid-operation: reset asserted with 2 outstanding, then late s_rvalid -> p_rvalid stays 0 and the next request is granted normally.
